sram_row_reader: RTL and testbench
==================================

# sram_row_reader

Streaming read engine for the `WIDTH`-bit activation/weight SRAM. On a `start` command it reads `row_count` consecutive rows beginning at `base_addr` and presents them on a valid/ready stream toward the systolic-array feeder. It hides the SRAM's 1-cycle registered read latency and absorbs downstream backpressure with a 2-entry buffer, so it sustains one row per cycle when `out_ready` is held high.

## Interface
- `WIDTH`, 512, row width in bits; must equal the SRAM width.
- `DEPTH`, 64, SRAM rows; must equal 2**`AW`.
- `AW`, 6, SRAM address width.

- `clk`  in  1  rising-edge clock shared with the SRAM.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  command strobe; sampled only in IDLE.
- `base_addr`  in  AW  first row address.
- `row_count`  in  AW+1  rows to read, 0..DEPTH; values above DEPTH saturate to DEPTH.
- `busy`  out  1  high from the cycle after an accepted start through the last beat handshake.
- `done`  out  1  one-cycle completion pulse.
- `sram_csb`  out  1  SRAM chip select, active-low; low only in read-issue cycles.
- `sram_wsb`  out  1  tied 1, so the block never writes.
- `sram_raddr`  out  AW  read address.
- `sram_rdata`  in  WIDTH  SRAM read data, valid the cycle after a csb=0 edge.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready.
- `out_data`  out  WIDTH  row data.
- `out_idx`  out  AW  row index within the burst, 0..row_count-1.
- `out_last`  out  1  high on the final beat of the burst.

## Operation
- FSM states: IDLE, RUN, FLUSH.
  - IDLE: on `start` with row_count≠0, latch the address and count, then go to RUN.
  - IDLE: on `start` with row_count=0, pulse `done` next cycle and stay in IDLE, with no SRAM access.
  - RUN: issue reads. Go to FLUSH in the cycle the last read is issued.
  - FLUSH: wait for the last beat handshake, then pulse `done` and return to IDLE.
- Read issue rule: in RUN, set `sram_csb`=0 with `sram_raddr`=base+i when `fifo_count + inflight - pop < 2`.
  - `inflight` is 1 if a read was issued the previous cycle.
  - `pop` = out_valid & out_ready.
  - The buffer therefore never overflows, and the SRAM is never re-read.
- Capture: the cycle after an issue, `sram_rdata` is pushed into the 2-entry FIFO, tagged with idx and last.
- Address arithmetic is modulo DEPTH: base=62 with count=4 reads rows 62, 63, 0, 1.
- `start` while `busy` is ignored.
- Stream rules:
  - `out_data`, `out_idx` and `out_last` are stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a handshake.
- Reset, including mid-burst: the FIFO is flushed, the burst is aborted, and no `done` is emitted.
- Reset values: busy=0, done=0, sram_csb=1, sram_wsb=1, sram_raddr=0, out_valid=0, out_data=0, out_idx=0, out_last=0.

## Timing
- Cycle 0: `start` sampled.
- Cycle 1: busy=1 and the first read issues (csb=0, raddr=base).
- Cycle 2: `sram_rdata` valid; pushed into the FIFO.
- Cycle 3: first out_valid. Start-to-first-valid latency is 3 cycles.
- With out_ready=1 continuously, beats appear in cycles 3..N+2 back-to-back; done=1 and busy=0 in cycle N+3.
- `done` is asserted the cycle after the last-beat handshake. `busy` falls in that same cycle.
- A new `start` is accepted in the `done` cycle.
- Under backpressure, at most 2 rows are buffered plus 0 in flight. Issue resumes the cycle a pop frees credit.
- FIFO push and pop in the same cycle is legal: occupancy is unchanged and order is preserved.

## Structure
- Package `tpu_sram_pkg`: default WIDTH/DEPTH/AW constants, the reader state enum (IDLE/RUN/FLUSH), and the beat struct {data, idx, last}.
- Sub-module `sram_rd_fifo2`: 2-entry synchronous FIFO of beat structs with count output; first-word-fall-through on the output.
- Top level contains the FSM, the address/issue counters, the credit logic and the inflight flag.

## Test plan
- Preload rows 0..7 with value k. Apply start, base=0, count=8, out_ready=1 → data 0..7 in cycles 3..10; out_last on idx 7; done in cycle 11; exactly 8 csb=0 cycles.
- base=62, count=4 → raddr sequence 62, 63, 0, 1; out_idx 0..3.
- count=4 with out_ready toggling 1,0,0,1,… → no lost or duplicated rows; data stable during stalls; never more than 2 reads outstanding beyond delivered beats; each address read exactly once.
- count=0 → done pulse one cycle after start; busy stays 0; csb stays 1.
- count=100 (saturates to 64) → exactly 64 beats; wsb=1 throughout.
- Assert rst in the cycle after the 3rd beat of a 10-row burst → next cycle out_valid=0, csb=1, busy=0, no done; a subsequent start with count=2 completes normally.

Source files
------------

// File: rtl/tpu_sram_pkg.sv
// Shared constants and types for the activation/weight SRAM row reader.
package tpu_sram_pkg;

  localparam int DEF_WIDTH = 512;
  localparam int DEF_DEPTH = 64;
  localparam int DEF_AW    = 6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } rd_state_e;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] data;
    logic [DEF_AW-1:0]    idx;
    logic                 last;
  } beat_t;

endpackage

// File: rtl/sram_row_reader_if.sv
// SRAM read port plus the outgoing row stream of the row reader.
interface sram_row_reader_if
  import tpu_sram_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW
);

  logic             sram_csb;
  logic             sram_wsb;
  logic [AW-1:0]    sram_raddr;
  logic [WIDTH-1:0] sram_rdata;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [AW-1:0]    out_idx;
  logic             out_last;

  modport master (
    output sram_csb, sram_wsb, sram_raddr,
    input  sram_rdata,
    output out_valid, out_data, out_idx, out_last,
    input  out_ready
  );

  modport slave (
    input  sram_csb, sram_wsb, sram_raddr,
    output sram_rdata,
    input  out_valid, out_data, out_idx, out_last,
    output out_ready
  );

endinterface

// File: rtl/sram_rd_fifo2.sv
// Two-entry first-word-fall-through FIFO of tagged SRAM rows.
module sram_rd_fifo2
  import tpu_sram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  beat_t      push_beat_i,
  input  logic       pop_i,
  output beat_t      head_o,
  output logic       valid_o,
  output logic [1:0] count_o
);

  beat_t      mem_q [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_pop;

  assign valid_o = (count_q != 2'd0);
  assign do_pop  = pop_i & valid_o;
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push_i;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    count_d  = count_q + {1'b0, push_i} - {1'b0, do_pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left unreset; the head is forced to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_beat_i;
    end
  end

  assign head_o = valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/sram_row_reader.sv
// Burst read engine: streams row_count SRAM rows from base_addr onto a valid/ready stream.
module sram_row_reader
  import tpu_sram_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AW-1:0]     base_addr,
  input  logic [AW:0]       row_count,
  output logic              busy,
  output logic              done,
  sram_row_reader_if.master bus
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  rd_state_e        state_q, state_d;
  logic [AW-1:0]    base_q, base_d;
  logic [AW:0]      total_q, total_d;
  logic [AW:0]      issued_q, issued_d;
  logic             inflight_q, inflight_d;
  logic [AW-1:0]    infl_idx_q, infl_idx_d;
  logic             infl_last_q, infl_last_d;
  logic             done_q, done_d;

  logic [AW:0]      count_sat;
  logic [AW:0]      issued_inc;
  logic [2:0]       occupancy;
  logic             pop;
  logic             issue;
  logic [WIDTH-1:0] rdata;
  beat_t            push_beat;
  beat_t            head;
  logic             head_valid;
  logic [1:0]       fifo_count;

  assign count_sat  = (row_count > DEPTH_L) ? DEPTH_L : row_count;
  assign issued_inc = issued_q + {{AW{1'b0}}, 1'b1};
  assign pop        = head_valid & bus.out_ready;

  // Credit: buffered rows plus the one in flight, less the one leaving, must leave room.
  assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign issue      = (state_q == RUN) && (occupancy < (3'd2 + {2'b00, pop}));

  assign rdata      = bus.sram_rdata;
  assign push_beat  = '{data: rdata, idx: infl_idx_q, last: infl_last_q};

  sram_rd_fifo2 u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_beat_i (push_beat),
    .pop_i       (pop),
    .head_o      (head),
    .valid_o     (head_valid),
    .count_o     (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    total_d     = total_q;
    issued_d    = issued_q;
    done_d      = 1'b0;
    inflight_d  = issue;
    infl_idx_d  = issued_q[AW-1:0];
    infl_last_d = (issued_inc == total_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          if (count_sat == '0) begin
            done_d = 1'b1;
          end else begin
            base_d   = base_addr;
            total_d  = count_sat;
            issued_d = '0;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        if (issue) begin
          issued_d = issued_inc;
          if (issued_inc == total_q) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (pop && head.last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      total_q     <= '0;
      issued_q    <= '0;
      inflight_q  <= 1'b0;
      infl_idx_q  <= '0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      total_q     <= total_d;
      issued_q    <= issued_d;
      inflight_q  <= inflight_d;
      infl_idx_q  <= infl_idx_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
    end
  end

  // Address wraps naturally at DEPTH because it is only AW bits wide.
  assign bus.sram_raddr = base_q + issued_q[AW-1:0];
  assign bus.sram_csb   = ~issue;
  assign bus.sram_wsb   = 1'b1;

  assign bus.out_valid  = head_valid;
  assign bus.out_data   = head.data;
  assign bus.out_idx    = head.idx;
  assign bus.out_last   = head.last;

  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_sram_row_reader.sv
// Scoreboard bench for sram_row_reader with a registered-read SRAM model.
module tb_sram_row_reader;

  localparam int WIDTH = 512;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   row_count;
  logic          busy;
  logic          done;

  sram_row_reader_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  sram_row_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .row_count (row_count),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] mem [DEPTH];

  always @(posedge clk) begin
    if (!bus.sram_csb) bus.sram_rdata <= mem[bus.sram_raddr];
  end

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [AW-1:0]    idx;
    logic             last;
  } expBeat_t;

  expBeat_t      expBeats[$];
  logic [AW-1:0] expAddr[$];
  int            totalChecks = 0;
  int            badChecks = 0;
  int            issuedCnt = 0;
  int            deliveredCnt = 0;
  int            csbCnt = 0;
  bit            rdSeen[DEPTH];
  bit            prevStall = 1'b0;

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic readyFor(input int mode, input int c);
    return (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
  endfunction

  task automatic clearScoreboard();
    expBeats.delete();
    expAddr.delete();
    issuedCnt    = 0;
    deliveredCnt = 0;
    csbCnt       = 0;
    for (int i = 0; i < DEPTH; i++) rdSeen[i] = 1'b0;
  endtask

  task automatic pushExpect(input int base, input int n);
    expBeat_t eb;
    int a;
    for (int i = 0; i < n; i++) begin
      a = (base + i) % DEPTH;
      expAddr.push_back(a[AW-1:0]);
      eb.data = mem[a];
      eb.idx  = i[AW-1:0];
      eb.last = (i == n - 1);
      expBeats.push_back(eb);
    end
  endtask

  // Stream and SRAM-port monitor, sampled mid-cycle.
  always @(negedge clk) begin : monitor
    logic popNow;
    if (rst) begin
      prevStall = 1'b0;
    end else begin
      popNow = bus.out_valid & bus.out_ready;
      if (prevStall) checkOutput("hold_valid", bus.out_valid, 1);
      if (bus.out_valid) begin
        if (expBeats.size() == 0) begin
          checkOutput("extra_beat", bus.out_valid, 0);
        end else begin
          checkOutput("beat_data", bus.out_data, expBeats[0].data);
          checkOutput("beat_idx", bus.out_idx, expBeats[0].idx);
          checkOutput("beat_last", bus.out_last, expBeats[0].last);
          if (popNow) void'(expBeats.pop_front());
        end
      end
      if (!bus.sram_csb) begin
        csbCnt++;
        checkOutput("wsb", bus.sram_wsb, 1);
        checkOutput("credit", ((issuedCnt - deliveredCnt - int'(popNow)) < 2), 1);
        checkOutput("read_once", rdSeen[bus.sram_raddr], 0);
        rdSeen[bus.sram_raddr] = 1'b1;
        if (expAddr.size() == 0) checkOutput("extra_read", bus.sram_csb, 1);
        else checkOutput("raddr", bus.sram_raddr, expAddr.pop_front());
        issuedCnt++;
      end
      if (popNow) deliveredCnt++;
      prevStall = bus.out_valid & !bus.out_ready;
    end
  end

  task automatic applyStimulus(input int base, input int cnt, input int mode, input int expDone);
    int n;
    int cycles;
    n = (cnt > DEPTH) ? DEPTH : cnt;
    clearScoreboard();
    pushExpect(base, n);
    bus.out_ready = readyFor(mode, 0);
    start     = 1'b1;
    base_addr = base[AW-1:0];
    row_count = cnt[AW:0];
    @(posedge clk); #1;
    start  = 1'b0;
    cycles = 1;
    bus.out_ready = readyFor(mode, cycles);
    if (n == 0) begin
      checkOutput("zero_done", done, 1);
      checkOutput("zero_busy", busy, 0);
      checkOutput("zero_csb", bus.sram_csb, 1);
      @(posedge clk); #1;
      checkOutput("zero_done_pulse", done, 0);
      checkOutput("zero_busy2", busy, 0);
      checkOutput("zero_reads", csbCnt, 0);
      return;
    end
    checkOutput("busy_c1", busy, 1);
    checkOutput("csb_c1", bus.sram_csb, 0);
    while (!done && cycles < 400) begin
      @(posedge clk); #1;
      cycles++;
      bus.out_ready = readyFor(mode, cycles);
      if (mode == 1 && cycles == 4) begin
        start     = 1'b1;
        base_addr = 6'd20;
        row_count = 7'd3;
      end else begin
        start = 1'b0;
      end
      if (mode == 0 && cycles == 2) checkOutput("valid_c2", bus.out_valid, 0);
      if (mode == 0 && cycles == 3) checkOutput("valid_c3", bus.out_valid, 1);
    end
    start = 1'b0;
    checkOutput("done_seen", done, 1);
    if (expDone >= 0) checkOutput("done_cycle", cycles, expDone);
    checkOutput("busy_done", busy, 0);
    checkOutput("beats_left", expBeats.size(), 0);
    checkOutput("csb_count", csbCnt, n);
    @(posedge clk); #1;
    checkOutput("done_pulse", done, 0);
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    base_addr     = '0;
    row_count     = '0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) mem[k] = {8{32'hC0DE0000 | 32'(k), 32'(k * 7 + 1)}};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_csb", bus.sram_csb, 1);
    checkOutput("rst_wsb", bus.sram_wsb, 1);
    checkOutput("rst_raddr", bus.sram_raddr, 0);
    checkOutput("rst_valid", bus.out_valid, 0);
    checkOutput("rst_data", bus.out_data, 0);
    checkOutput("rst_idx", bus.out_idx, 0);
    checkOutput("rst_last", bus.out_last, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] burst base=0 count=8");
    applyStimulus(0, 8, 0, 11);
    $display("[TB] wrapping burst base=62 count=4");
    applyStimulus(62, 4, 0, 7);
    $display("[TB] backpressure burst count=4");
    applyStimulus(3, 4, 1, -1);
    $display("[TB] empty burst");
    applyStimulus(9, 0, 0, -1);
    $display("[TB] saturating burst count=100");
    applyStimulus(10, 100, 0, 67);

    $display("[TB] reset mid-burst");
    begin
      int cycles;
      clearScoreboard();
      pushExpect(0, 10);
      bus.out_ready = 1'b1;
      start     = 1'b1;
      base_addr = 6'd0;
      row_count = 7'd10;
      @(posedge clk); #1;
      start  = 1'b0;
      cycles = 1;
      while (cycles < 6) begin
        @(posedge clk); #1;
        cycles++;
      end
      checkOutput("rst_beats3", deliveredCnt, 3);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("abort_valid", bus.out_valid, 0);
      checkOutput("abort_csb", bus.sram_csb, 1);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_done", done, 0);
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        checkOutput("abort_no_done", done, 0);
        checkOutput("abort_idle_valid", bus.out_valid, 0);
      end
    end
    applyStimulus(5, 2, 0, 5);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
